cursor_pos_arbiter: RTL
=======================

Name: cursor_pos_arbiter

Overview:
Frame-synchronous scheduler for the cursor-overlay position inputs (xpos/ypos) of the mouse drawing stage in the VGA pipeline. It arbitrates between two position sources: live mouse coordinates, and game-generated coordinates used for demo/auto-aim. Positions are committed only at the start of vertical blanking, so the overlay never tears mid-frame. Coordinates are clamped to the active area, and ownership hands over cleanly with a one-frame hold.

Parameters:
H_ACTIVE, 800, active pixels per line; x clamp limit is H_ACTIVE-1
V_ACTIVE, 600, active lines per frame; y clamp limit is V_ACTIVE-1
IDLE_FRAMES, 60, consecutive mouse-idle frames needed before the game may take ownership (range 1..255)

Ports:
clk60MHz  in  1  pixel clock; the block's only clock
rst  in  1  reset, asynchronous, active-low
vblnk  in  1  vertical blank from the VGA timing chain
m_valid  in  1  mouse sample strobe, one cycle per new sample
m_x  in  12  mouse x
m_y  in  12  mouse y
g_valid  in  1  game position request
g_x  in  12  game x
g_y  in  12  game y
g_ready  out  1  game handshake ready
game_mode  in  1  game requests cursor ownership (level)
xpos  out  12  committed cursor x to the draw stage
ypos  out  12  committed cursor y to the draw stage
owner  out  2  00 = mouse, 01 = game, 10 = hold
frame_tick  out  1  one-cycle pulse, aligned with each commit edge

Behaviour:
- Reset (rst low, asynchronous):
  - xpos = H_ACTIVE/2, ypos = V_ACTIVE/2, owner = 00, frame_tick = 0.
  - g_ready = 1; both pending buffers empty; idle counter = 0; vblnk_d = 0; state = S_MOUSE.
- Frame edge: tick_c = vblnk & ~vblnk_d (combinational). vblnk_d is registered every cycle.
- On the clock edge where tick_c = 1:
  - commit and state transitions occur together;
  - frame_tick goes high for exactly one cycle;
  - xpos, ypos and owner change on that same edge.
- Mouse buffer (latest wins):
  - Every m_valid cycle loads m_x/m_y into the mouse buffer and sets m_pend; there is no backpressure.
  - If m_valid coincides with a mouse commit, the commit uses the old buffer contents. The new sample stays pending (m_pend remains 1).
- Game buffer (strict valid/ready):
  - g_ready = ~g_pend; a transfer occurs when g_valid & g_ready, and sets g_pend.
  - The buffer clears only when committed, so g_ready rises the cycle after the commit edge.
  - A game request held while the mouse owns stays pending indefinitely; it is never dropped.
- Commit at tick, based on the current (pre-transition) state:
  - S_MOUSE with m_pend: commit the mouse buffer, clear m_pend.
  - S_GAME with g_pend: commit the game buffer, clear g_pend.
  - S_HOLD: no commit.
  - If nothing is pending, the outputs hold their values.
- Clamp: x = min(buf_x, H_ACTIVE-1), y = min(buf_y, V_ACTIVE-1). Unsigned compare, 12-bit, no wrap.
- Idle counter (in S_MOUSE only):
  - At each tick, reset to 0 if m_pend was set, otherwise increment, saturating at IDLE_FRAMES.
  - Cleared on leaving S_MOUSE.
- FSM (transitions only at tick):
  - S_MOUSE -> S_GAME when game_mode = 1 and idle counter == IDLE_FRAMES before this tick's update, and m_pend = 0.
  - S_GAME -> S_HOLD when m_pend = 1. Mouse preempts; the mouse sample is not committed this tick.
  - S_GAME -> S_MOUSE when game_mode = 0 and m_pend = 0.
  - If both conditions hold, S_HOLD wins.
  - S_HOLD -> S_MOUSE unconditionally at the next tick. The position is frozen for exactly one frame; the pending mouse sample commits at the tick after that.
- owner reflects the state after the tick edge.
- vblnk held high across reset release: vblnk_d is 0, so the first cycle after reset release produces a tick. This is intended; a tick with nothing pending changes no position.
- Reset asserted mid-frame aborts any handover and discards both buffers.

Test Plan:
- Reset release with vblnk = 0 -> xpos = 400, ypos = 300, owner = 00, g_ready = 1, frame_tick = 0.
- Mouse m_x = 100, m_y = 50 pulsed mid-frame, then vblnk rises -> on that edge xpos = 100, ypos = 50, frame_tick = 1 for one cycle; no change before vblnk.
- Mouse m_x = 900, m_y = 700, then tick -> xpos = 799, ypos = 599. Second case: m_valid = 200 on the exact tick edge after an earlier 100 -> commits 100, then 200 at the next tick.
- game_mode = 1, game request (10, 20) accepted (g_ready drops), no mouse activity for 60 frames -> owner = 01 at tick 61. Game commit (10, 20) at tick 62; g_ready = 1 on the following cycle.
- In S_GAME, mouse pulse (300, 300) -> next tick owner = 10 with position unchanged; following tick owner = 00; the tick after that gives xpos = ypos = 300.
- rst pulsed low while owner = 01 with g_pend = 1 -> outputs immediately return to reset values, g_ready = 1, owner = 00.

Source files
------------

// File: rtl/cursor_pos_arbiter_if.sv
// cursor_pos_arbiter_if: position sources, vblank input and committed cursor outputs of the arbiter
interface cursor_pos_arbiter_if;
    logic        vblnk;
    logic        m_valid;
    logic [11:0] m_x;
    logic [11:0] m_y;
    logic        g_valid;
    logic [11:0] g_x;
    logic [11:0] g_y;
    logic        g_ready;
    logic        game_mode;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic [1:0]  owner;
    logic        frame_tick;

    modport master (
        output vblnk, m_valid, m_x, m_y, g_valid, g_x, g_y, game_mode,
        input  g_ready, xpos, ypos, owner, frame_tick
    );

    modport slave (
        input  vblnk, m_valid, m_x, m_y, g_valid, g_x, g_y, game_mode,
        output g_ready, xpos, ypos, owner, frame_tick
    );
endinterface

// File: rtl/cursor_pos_arbiter.sv
// cursor_pos_arbiter: commits mouse or game cursor positions only at the start of vblank
module cursor_pos_arbiter #(
    parameter int H_ACTIVE    = 800,
    parameter int V_ACTIVE    = 600,
    parameter int IDLE_FRAMES = 60
) (
    input  logic                 clk60MHz,
    input  logic                 rst,
    cursor_pos_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {S_MOUSE = 2'b00, S_GAME = 2'b01, S_HOLD = 2'b10} state_t;

    localparam logic [11:0] X_MAX    = 12'(H_ACTIVE - 1);
    localparam logic [11:0] Y_MAX    = 12'(V_ACTIVE - 1);
    localparam logic [7:0]  IDLE_MAX = 8'(IDLE_FRAMES);

    state_t      state, nxt;
    logic        vblnk_d, tick, m_pend, g_pend, commit_m, commit_g, g_xfer;
    logic [11:0] m_bx, m_by, g_bx, g_by, src_x, src_y;
    logic [7:0]  idle;

    assign tick        = bus.vblnk & ~vblnk_d;
    assign commit_m    = tick & (state == S_MOUSE) & m_pend;
    assign commit_g    = tick & (state == S_GAME) & g_pend;
    assign g_xfer      = bus.g_valid & ~g_pend;
    assign bus.g_ready = ~g_pend;
    assign src_x       = commit_g ? g_bx : m_bx;
    assign src_y       = commit_g ? g_by : m_by;

    // ownership for the coming frame; a pending mouse sample preempts the game via a one-frame hold
    always_comb
        nxt = !tick             ? state :
              state == S_MOUSE  ? ((bus.game_mode && idle == IDLE_MAX && !m_pend) ? S_GAME : S_MOUSE) :
              state == S_GAME   ? (m_pend ? S_HOLD : (bus.game_mode ? S_GAME : S_MOUSE)) :
                                  S_MOUSE;

    // buffers, idle counting, ownership and the committed position all move on the frame edge
    always_ff @(posedge clk60MHz or negedge rst) begin
        if (!rst) begin
            state          <= S_MOUSE;
            vblnk_d        <= 1'b0;
            m_pend         <= 1'b0;
            g_pend         <= 1'b0;
            m_bx           <= '0;
            m_by           <= '0;
            g_bx           <= '0;
            g_by           <= '0;
            idle           <= '0;
            bus.xpos       <= 12'(H_ACTIVE / 2);
            bus.ypos       <= 12'(V_ACTIVE / 2);
            bus.owner      <= 2'b00;
            bus.frame_tick <= 1'b0;
        end else begin
            vblnk_d        <= bus.vblnk;
            bus.frame_tick <= tick;
            state          <= nxt;
            bus.owner      <= nxt;
            if (bus.m_valid) begin
                m_bx <= bus.m_x;
                m_by <= bus.m_y;
            end
            m_pend <= bus.m_valid | (m_pend & ~commit_m);
            if (g_xfer) begin
                g_bx <= bus.g_x;
                g_by <= bus.g_y;
            end
            g_pend <= g_xfer | (g_pend & ~commit_g);
            if (commit_m | commit_g) begin
                bus.xpos <= (src_x > X_MAX) ? X_MAX : src_x;
                bus.ypos <= (src_y > Y_MAX) ? Y_MAX : src_y;
            end
            if (tick)
                idle <= (state == S_MOUSE && nxt == S_MOUSE && !m_pend) ?
                        ((idle == IDLE_MAX) ? idle : idle + 8'd1) : 8'd0;
        end
    end
endmodule
